// File: rtl/inst_stream_encoder_if.sv
// rtl/inst_stream_encoder_if.sv - request and instruction-memory write bus of the instruction stream encoder
//
// Groups the two handshaked paths of the encoder:
//   request path : in_valid/in_ready/in_last plus instruction fields
//                  (in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target)
//   write path   : im_wr_en/im_ready plus im_addr/im_wdata
// modport slave  : the encoder (consumes requests, issues memory writes)
// modport master : the loader side (issues requests, accepts memory writes)
interface inst_stream_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              im_wr_en;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport slave (
        input  in_valid, in_last, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        output in_ready,
        output im_wr_en, im_addr, im_wdata,
        input  im_ready
    );

    modport master (
        output in_valid, in_last, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        input  in_ready,
        input  im_wr_en, im_addr, im_wdata,
        output im_ready
    );
endinterface

// File: rtl/inst_stream_encoder.sv
// rtl/inst_stream_encoder.sv - encodes MIPS instruction requests and streams them into instruction memory
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start/base_addr begin a load session at base_addr (honoured only in IDLE)
//   bus (slave)     request handshake in, instruction-memory write port out
//   word_cnt        words written this session (saturating)
//   busy            session in RUN or DRAIN
//   done            one-cycle pulse at session end
//   err             sticky field-check error
// Optional macro INST_FIELD_CHECK_EN enables the unused-field check driving err;
// without it err is tied low. Masking of unused fields is identical either way.
module inst_stream_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    inst_stream_encoder_if.slave bus,
    output logic [15:0]         word_cnt,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] K_ADDU = 3'd0;
    localparam logic [2:0] K_SUBU = 3'd1;
    localparam logic [2:0] K_ORI  = 3'd2;
    localparam logic [2:0] K_SLL  = 3'd3;
    localparam logic [2:0] K_LW   = 3'd4;
    localparam logic [2:0] K_SW   = 3'd5;
    localparam logic [2:0] K_BEQ  = 3'd6;
    localparam logic [2:0] K_J    = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      enc_word;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_CNT);
    // No full-bypass: a pop in the same cycle does not reopen in_ready.
    assign bus.in_ready = (state == RUN) && !fifo_full;
    assign bus.im_wr_en = !fifo_empty;
    assign bus.im_wdata = mem[rd_ptr];
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.im_wr_en && bus.im_ready;
    assign busy         = (state == RUN) || (state == DRAIN);
    assign done         = (state == DONE);

    // Unused fields are dropped by construction of each encoding.
    always_comb begin
        enc_word = 32'h0;
        case (bus.in_kind)
            K_ADDU:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21};
            K_SUBU:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h23};
            K_ORI:   enc_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
            K_SLL:   enc_word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
            K_LW:    enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            K_SW:    enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            K_BEQ:   enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            K_J:     enc_word = {6'h02, bus.in_target};
            default: enc_word = 32'h0;
        endcase
    end

    // Storage is not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.im_addr <= '0;
            word_cnt    <= 16'h0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.im_addr <= bus.im_addr + ADDR_W'(4);
                if (word_cnt != 16'hFFFF) begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // The FIFO is always empty in IDLE, so the start load never races a pop.
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.im_addr <= base_addr;
                        word_cnt    <= 16'h0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (push && bus.in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INST_FIELD_CHECK_EN
    logic field_bad;

    always_comb begin
        field_bad = 1'b0;
        case (bus.in_kind)
            K_SLL:                     field_bad = (bus.in_rs != 5'd0);
            K_ADDU, K_SUBU:            field_bad = (bus.in_shamt != 5'd0);
            K_ORI, K_LW, K_SW, K_BEQ:  field_bad = (bus.in_rd != 5'd0) || (bus.in_shamt != 5'd0);
            K_J:                       field_bad = (bus.in_rs != 5'd0) || (bus.in_rt != 5'd0) ||
                                                   (bus.in_rd != 5'd0) || (bus.in_shamt != 5'd0) ||
                                                   (bus.in_imm != 16'h0);
            default:                   field_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err <= 1'b0;
        end else if (push && field_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: doc/inst_stream_encoder.md
Name: inst_stream_encoder

Overview:
- Encoder counterpart of the CPU instruction decoder: turns abstract instruction requests into 32-bit MIPS words for the supported subset (addu, subu, ori, sll, lw, sw, beq, j).
- Buffers the encoded words in a small FIFO and writes them sequentially into instruction memory through a stallable write port.
- Used by the test/boot loader to fill instruction memory before the multicycle CPU runs.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 32, width of instruction-memory byte address

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a load session; sampled only in IDLE
base_addr  input  ADDR_W  first byte address, latched on accepted start
in_valid  input  1  instruction request valid
in_ready  output  1  encoder can accept request
in_last  input  1  marks final request of session
in_kind  input  3  0 addu, 1 subu, 2 ori, 3 sll, 4 lw, 5 sw, 6 beq, 7 j
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field
in_shamt  input  5  shift amount
in_imm  input  16  immediate / offset
in_target  input  26  jump target
im_wr_en  output  1  write request to instruction memory
im_ready  input  1  memory accepts write this cycle
im_addr  output  ADDR_W  byte address of write
im_wdata  output  32  encoded instruction
word_cnt  output  16  words written this session
busy  output  1  high in RUN or DRAIN
done  output  1  one-cycle pulse at session end
err  output  1  field-check error (see Optional Feature)

Behaviour:
- Reset when rst_n=0 at a clk edge: state IDLE, FIFO emptied (contents dropped), im_addr=0, word_cnt=0; in_ready, im_wr_en, busy, done and err all 0. Reset mid-session aborts the session with no done pulse.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: start=1 latches im_addr<=base_addr, clears word_cnt, goes to RUN.
  - RUN: accepts requests. When the beat with in_last=1 is accepted, goes to DRAIN.
  - DRAIN: goes to DONE in the cycle in which the FIFO is empty.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Input handshake:
  - in_ready = (state==RUN) && FIFO not full. There is no full-bypass: at full, in_ready=0 even if a pop happens in the same cycle.
  - A beat is accepted when in_valid && in_ready.
  - The encoded word is written into the FIFO at that clk edge. The earliest im_wr_en is the following cycle (latency 1).
- Encoding is combinational from the in_* fields. Fields not used by the instruction kind are forced to 0:
  - addu: op 0, rs, rt, rd, shamt 0, funct 0x21
  - subu: as addu, funct 0x23
  - sll: op 0, rs 0, rt, rd, shamt, funct 0x00
  - ori: op 0x0D, rs, rt, imm
  - lw: op 0x23, rs, rt, imm
  - sw: op 0x2B, rs, rt, imm
  - beq: op 0x04, rs, rt, imm
  - j: op 0x02, target
- Output side:
  - im_wr_en = FIFO not empty; im_wdata = FIFO head.
  - Write completes when im_wr_en && im_ready. On completion: pop, im_addr += 4 (wraps modulo 2^ADDR_W), word_cnt += 1 (saturates at 0xFFFF).
  - im_wdata and im_addr stay stable while im_wr_en=1 and im_ready=0.
- Push and pop in the same cycle leave the occupancy unchanged. Pointers wrap modulo DEPTH.
- busy=1 in RUN and DRAIN. word_cnt holds its value after DONE until the next start.

Optional Feature:
- Macro INST_FIELD_CHECK_EN.
- Defined: on each accepted beat, err is set sticky if any unused field is nonzero:
  - rs for sll;
  - shamt for addu or subu;
  - rd or shamt for ori, lw, sw, beq;
  - any of rs, rt, rd, shamt, imm for j.
  The word is still written with those fields masked. err clears on accepted start or on reset.
- Undefined: no checking logic; err tied to 0. Masking is unchanged.

Test Plan:
- start with base_addr=0x100; addu rs=1 rt=2 rd=3 with in_last, im_ready=1 -> im_wdata=0x00221821 at im_addr=0x100; done pulses once; word_cnt=1.
- Sequence ori rt=5 imm=0x00FF; lw rs=29 rt=8 imm=0x0004; sll rt=2 rd=4 shamt=2; beq rs=1 rt=2 imm=0xFFFE; j target=0x10 -> words 0x340500FF, 0x8FA80004, 0x00022080, 0x1022FFFE, 0x08000010 at addresses 0x100, 0x104, 0x108, 0x10C, 0x110.
- im_ready=0, 5 requests offered with DEPTH=4 -> in_ready drops after 4 accepts and im_addr/im_wdata stay stable. Then im_ready=1 -> all 5 written in order, and the FSM leaves DRAIN only when the FIFO is empty.
- rst_n=0 while in DRAIN with 3 words queued -> next cycle im_wr_en=0, busy=0, state IDLE, no done pulse.
- start asserted during RUN -> ignored, im_addr unchanged. base_addr=0xFFFFFFFC with two words -> second write at address 0x00000000.
- With INST_FIELD_CHECK_EN: j with rs=3 -> err=1 and word 0x08000000 | target. Without the macro, same stimulus -> err=0 and the same word.
